// File: rtl/gf_regfile_acc.sv
// gf_regfile_acc: GF(2^M) register file with a multi-cycle masked XOR
// accumulator. Each ACC cycle folds LANES entries into the running sum, so a
// full pass takes ceil(DEPTH/LANES) cycles regardless of the mask value.
// Optional feature macro: RF_ACC_WB_EN adds wb_en/wb_addr so that the result
// can be written back into the file on the same edge that updates acc_data.
module gf_regfile_acc #(
  parameter int M     = 8,
  parameter int DEPTH = 6,
  parameter int LANES = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [M-1:0]     wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [M-1:0]     rd_data,
  output logic             rd_valid,
  input  logic             acc_start,
  input  logic [DEPTH-1:0] acc_mask,
  output logic             acc_busy,
  output logic             acc_done,
  output logic [M-1:0]     acc_data
`ifdef RF_ACC_WB_EN
  ,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr
`endif
);

  // Index wide enough to hold idx + LANES without wrapping.
  localparam int IW = $clog2(DEPTH + LANES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     mem_q [DEPTH];
  logic [M-1:0]     mem_d [DEPTH];
  logic [M-1:0]     rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [M-1:0]     acc_q, acc_d;
  logic [M-1:0]     acc_data_q, acc_data_d;
  logic             acc_done_q, acc_done_d;
  logic             acc_busy_q, acc_busy_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DEPTH-1:0] mask_q, mask_d;
  logic             wb_en_q, wb_en_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic [M-1:0]     lane_x;
  logic [M-1:0]     acc_next;
  logic             wb_en_in;
  logic [AW-1:0]    wb_addr_in;

`ifdef RF_ACC_WB_EN
  assign wb_en_in   = wb_en;
  assign wb_addr_in = wb_addr;
`else
  assign wb_en_in   = 1'b0;
  assign wb_addr_in = '0;
`endif

  // Next-state logic: register file access, accumulator FSM and write-back.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    acc_d      = acc_q;
    acc_data_d = acc_data_q;
    acc_done_d = 1'b0;
    acc_busy_d = acc_busy_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    wb_en_d    = wb_en_q;
    wb_addr_d  = wb_addr_q;

    // XOR of the masked entries in the current group; positions past DEPTH
    // simply never match, so they contribute zero.
    lane_x = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((IW'(j) >= idx_q) && (IW'(j) < (idx_q + IW'(LANES))) && mask_q[DEPTH-1-j]) begin
        lane_x = lane_x ^ mem_q[j];
      end else begin
        lane_x = lane_x;
      end
    end
    acc_next = acc_q ^ lane_x;

    // Reads sample the pre-write contents; out-of-range addresses return 0.
    if (rd_en) begin
      rd_data_d = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (rd_addr == AW'(j)) begin
          rd_data_d = mem_q[j];
        end else begin
          rd_data_d = rd_data_d;
        end
      end
    end else begin
      rd_data_d = rd_data_q;
    end

    case (state_q)
      S_IDLE: begin
        // External writes land only while idle, ahead of a same-cycle start.
        for (int j = 0; j < DEPTH; j++) begin
          if (wr_en && (wr_addr == AW'(j))) begin
            mem_d[j] = wr_data;
          end else begin
            mem_d[j] = mem_d[j];
          end
        end
        if (acc_start) begin
          state_d    = S_ACC;
          mask_d     = acc_mask;
          acc_d      = '0;
          idx_d      = '0;
          acc_busy_d = 1'b1;
          wb_en_d    = wb_en_in;
          wb_addr_d  = wb_addr_in;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ACC: begin
        acc_d = acc_next;
        idx_d = idx_q + IW'(LANES);
        if ((idx_q + IW'(LANES)) >= IW'(DEPTH)) begin
          state_d    = S_DONE;
          acc_data_d = acc_next;
          acc_done_d = 1'b1;
          for (int j = 0; j < DEPTH; j++) begin
            if (wb_en_q && (wb_addr_q == AW'(j))) begin
              mem_d[j] = acc_next;
            end else begin
              mem_d[j] = mem_d[j];
            end
          end
        end else begin
          state_d = S_ACC;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        acc_busy_d = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        acc_busy_d = 1'b0;
      end
    endcase
  end

  // State registers; async reset clears everything and aborts any pass.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      acc_q      <= '0;
      acc_data_q <= '0;
      acc_done_q <= 1'b0;
      acc_busy_q <= 1'b0;
      idx_q      <= '0;
      mask_q     <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      acc_q      <= acc_d;
      acc_data_q <= acc_data_d;
      acc_done_q <= acc_done_d;
      acc_busy_q <= acc_busy_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign acc_busy = acc_busy_q;
  assign acc_done = acc_done_q;
  assign acc_data = acc_data_q;

endmodule

// File: tb/tb_gf_regfile_acc.sv
// Scoreboard bench for gf_regfile_acc (M=8, DEPTH=6, LANES=2, K=3).
module tb_gf_regfile_acc;
  localparam int M     = 8;
  localparam int DEPTH = 6;
  localparam int LANES = 2;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [M-1:0]     wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [M-1:0]     rd_data;
  logic             rd_valid;
  logic             acc_start;
  logic [DEPTH-1:0] acc_mask;
  logic             acc_busy;
  logic             acc_done;
  logic [M-1:0]     acc_data;

  gf_regfile_acc #(.M(M), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .rst_b(rst_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .acc_start(acc_start), .acc_mask(acc_mask), .acc_busy(acc_busy),
    .acc_done(acc_done), .acc_data(acc_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [M-1:0] data;
    int           when;
  } acc_exp_t;

  logic [M-1:0] rd_exp_q [$];
  acc_exp_t     acc_exp_q [$];
  logic [M-1:0] ref_mem [DEPTH];
  int           busy_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: GF(2^8) sum of the entries whose mask bit (MSB = entry 0) is set.
  function automatic logic [M-1:0] ref_acc(input logic [DEPTH-1:0] mask);
    logic [M-1:0] r = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mask[DEPTH-1-i]) r = r ^ ref_mem[i];
    return r;
  endfunction

  // Monitor: pop expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      if (rd_valid === 1'b1) begin
        if (rd_exp_q.size() == 0) check("unexpected_rd_valid", 32'd1, 32'd0);
        else check("rd_data", {24'd0, rd_data}, {24'd0, rd_exp_q.pop_front()});
      end
      if (acc_done === 1'b1) begin
        if (acc_exp_q.size() == 0) check("unexpected_acc_done", 32'd1, 32'd0);
        else begin
          acc_exp_t e;
          e = acc_exp_q.pop_front();
          check("acc_data", {24'd0, acc_data}, {24'd0, e.data});
          check("acc_done_cycle", cyc, e.when);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; acc_start = 1'b0;
  endtask

  // One cycle of stimulus; the model is updated with the spec's rules.
  task automatic op(input bit do_wr, input int wa, input logic [M-1:0] wd,
                    input bit do_rd, input int ra,
                    input bit do_acc, input logic [DEPTH-1:0] mask);
    bit busy;
    busy = (busy_left > 0);
    if (do_rd) rd_exp_q.push_back((ra < DEPTH) ? ref_mem[ra] : 8'h00);
    if (do_wr && !busy && wa < DEPTH) ref_mem[wa] = wd;
    if (busy) busy_left--;
    if (do_acc && !busy) begin
      acc_exp_t e;
      e.data = ref_acc(mask);
      e.when = cyc + 4;
      acc_exp_q.push_back(e);
      busy_left = 4;
    end
    wr_en = do_wr; wr_addr = AW'(wa); wr_data = wd;
    rd_en = do_rd; rd_addr = AW'(ra);
    acc_start = do_acc; acc_mask = mask;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 8'h00, 0, 0, 0, 6'd0);
  endtask

  // Start an accumulation and check the busy/done window cycle by cycle.
  task automatic acc_timed(input logic [DEPTH-1:0] mask, input string tag);
    op(0, 0, 8'h00, 0, 0, 1, mask);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check({tag, "_busy"}, {31'd0, acc_busy}, {31'd0, (k <= 4)});
      check({tag, "_done"}, {31'd0, acc_done}, {31'd0, (k == 4)});
      op(0, 0, 8'h00, 0, 0, 0, 6'd0);
    end
  endtask

  initial begin
    wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;
    acc_start = 0; acc_mask = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_acc_busy", {31'd0, acc_busy}, 32'd0);
    check("rst_acc_done", {31'd0, acc_done}, 32'd0);
    check("rst_acc_data", {24'd0, acc_data}, 32'd0);
    rst_b = 1'b1;
    for (int a = 0; a < DEPTH; a++) op(0, 0, 8'h00, 1, a, 0, 6'd0);
    idle(2);

    // Load one-hot values and run the directed accumulations.
    for (int a = 0; a < DEPTH; a++) op(1, a, 8'(1 << a), 0, 0, 0, 6'd0);
    acc_timed(6'b101001, "m29");
    acc_timed(6'b111111, "m3f");
    acc_timed(6'b000000, "m00");

    // Mid-ACC start is ignored and a write to entry 2 is dropped.
    op(0, 0, 8'h00, 0, 0, 1, 6'b111111);
    op(1, 2, 8'hFF, 0, 0, 1, 6'b000001);
    idle(4);
    op(0, 0, 8'h00, 1, 2, 0, 6'd0);
    // Same-cycle write/read of address 1 returns the old value.
    op(1, 1, 8'h55, 1, 1, 0, 6'd0);
    op(0, 0, 8'h00, 1, 1, 0, 6'd0);
    // Out-of-range write ignored, read returns 0.
    op(1, 7, 8'hAA, 1, 7, 0, 6'd0);
    // Write and start in the same cycle: accumulation sees the new value.
    op(1, 0, 8'hC3, 0, 0, 1, 6'b100000);
    idle(5);

    // Randomized traffic, including activity while busy.
    for (int n = 0; n < 400; n++) begin
      op($urandom_range(0, 2) == 0, $urandom_range(0, 7), 8'($urandom),
         $urandom_range(0, 1) == 0, $urandom_range(0, 7),
         $urandom_range(0, 4) == 0, 6'($urandom));
    end
    idle(6);

    // Reset in the middle of an accumulation aborts it.
    op(0, 0, 8'h00, 0, 0, 1, 6'b111111);
    op(0, 0, 8'h00, 0, 0, 0, 6'd0);
    rst_b = 1'b0;
    #2;
    rd_exp_q.delete();
    acc_exp_q.delete();
    busy_left = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    check("midrst_busy", {31'd0, acc_busy}, 32'd0);
    check("midrst_done", {31'd0, acc_done}, 32'd0);
    check("midrst_acc_data", {24'd0, acc_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle(5);
    for (int a = 0; a < DEPTH; a++) op(0, 0, 8'h00, 1, a, 0, 6'd0);
    idle(3);

    check("rd_queue_drained", rd_exp_q.size(), 32'd0);
    check("acc_queue_drained", acc_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
